// File: rtl/addsub_serial_if.sv
// Request/response bundle for addsub_serial. The master side drives start/op/a/b,
// and the slave side returns busy, done, result and the flags.
interface addsub_serial_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             neg;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry, overflow, zero, neg
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry, overflow, zero, neg
  );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract, DIGIT bits per clock, LSB digit first, with carry/overflow/zero/neg.
// Define ADDSUB_SAT_EN to clamp the result on signed overflow; the default build wraps.
module addsub_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  addsub_serial_if.slave bus
);
  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             cy_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q, carry_q, overflow_q, zero_q, neg_q;
  logic [WIDTH-1:0] result_q;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] final_res;
  logic             msb_cin;
  logic             ovf;
  logic             last;

  always_comb begin
    dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy_q};
    acc_d   = (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    // On the last digit, bit DIGIT-1 of the digit is bit WIDTH-1 of the word.
    msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
    ovf     = msb_cin ^ dsum[DIGIT];
    last    = (cnt_q == CntW'(N - 1));
    final_res = acc_d;
`ifdef ADDSUB_SAT_EN
    // Overflow implies both effective operands share a sign; A's sign picks the clamp.
    if (ovf) begin
      final_res = a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cy_q       <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.op ? ~bus.b : bus.b;
            cy_q    <= bus.op;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          acc_q <= acc_d;
          cy_q  <= dsum[DIGIT];
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q    <= StDone;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            result_q   <= final_res;
            carry_q    <= dsum[DIGIT];
            overflow_q <= ovf;
            zero_q     <= (final_res == '0);
            neg_q      <= final_res[WIDTH-1];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;
  assign bus.neg      = neg_q;
endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: a DIGIT=4 instance (N=8) and a DIGIT=32 instance (N=1).
module tb_addsub_serial;
  typedef struct {
    bit          op;
    logic [31:0] a, b, res;
    logic        c, v, z, n;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        c, v, z, n;
    int          cyc;
  } exp_t;

`ifdef ADDSUB_SAT_EN
  localparam logic [31:0] R_OVF_ADD = 32'h7FFF_FFFF;
  localparam logic        N_OVF_ADD = 1'b0;
  localparam logic [31:0] R_OVF_SUB = 32'h8000_0000;
  localparam logic        N_OVF_SUB = 1'b1;
`else
  localparam logic [31:0] R_OVF_ADD = 32'h8000_0000;
  localparam logic        N_OVF_ADD = 1'b1;
  localparam logic [31:0] R_OVF_SUB = 32'h7FFF_FFFF;
  localparam logic        N_OVF_SUB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q4[$];
  exp_t q32[$];
  vec_t vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_serial_if #(.WIDTH(32)) if4 ();
  addsub_serial_if #(.WIDTH(32)) if32 ();

  addsub_serial #(.WIDTH(32), .DIGIT(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  addsub_serial #(.WIDTH(32), .DIGIT(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: raises start for the following accept edge, then drops it.
  task automatic issue(input bit sel, input vec_t v, input bit push);
    exp_t e;
    e.res = v.res; e.c = v.c; e.v = v.v; e.z = v.z; e.n = v.n;
    e.cyc = cyc + 1 + (sel ? 1 : 8);
    if (sel) begin
      if32.start = 1'b1; if32.op = v.op; if32.a = v.a; if32.b = v.b;
    end else begin
      if4.start = 1'b1; if4.op = v.op; if4.a = v.a; if4.b = v.b;
    end
    if (push) begin
      if (sel) q32.push_back(e);
      else     q4.push_back(e);
    end
    @(negedge clk);
    if (sel) begin
      if32.start = 1'b0;
      chk("busy_after_start32", 32'(if32.busy), 32'd1);
    end else begin
      if4.start = 1'b0;
      chk("busy_after_start4", 32'(if4.busy), 32'd1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q4.size() != 0 || q32.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    chk("drain_pending", 32'(q4.size() + q32.size()), 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest expected entry, value and cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if4.done) begin
        if (q4.size() == 0) begin
          chk("unexpected_done4", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q4.pop_front();
          chk("result4", if4.result, e.res);
          chk("carry4", 32'(if4.carry), 32'(e.c));
          chk("overflow4", 32'(if4.overflow), 32'(e.v));
          chk("zero4", 32'(if4.zero), 32'(e.z));
          chk("neg4", 32'(if4.neg), 32'(e.n));
          chk("done_cycle4", 32'(cyc), 32'(e.cyc));
          chk("busy_at_done4", 32'(if4.busy), 32'd0);
        end
      end
      if (if32.done) begin
        if (q32.size() == 0) begin
          chk("unexpected_done32", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q32.pop_front();
          chk("result32", if32.result, e.res);
          chk("carry32", 32'(if32.carry), 32'(e.c));
          chk("overflow32", 32'(if32.overflow), 32'(e.v));
          chk("zero32", 32'(if32.zero), 32'(e.z));
          chk("neg32", 32'(if32.neg), 32'(e.n));
          chk("done_cycle32", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    vec_t junk;
    //            op    a             b             res           c     v     z     n
    vecs[0] = '{1'b1, 32'd5,        32'd3,        32'd2,        1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'd0,        32'd1,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'd1,       R_OVF_ADD,    1'b0, 1'b1, 1'b0, N_OVF_ADD};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'd1,       R_OVF_SUB,    1'b1, 1'b1, 1'b0, N_OVF_SUB};
    vecs[5] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'd3,        32'd3,        32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
    junk    = '{1'b1, 32'd1,        32'd2,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0};

    if4.start = 1'b0;  if4.op = 1'b0;  if4.a = '0;  if4.b = '0;
    if32.start = 1'b0; if32.op = 1'b0; if32.a = '0; if32.b = '0;

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(if4.busy), 32'd0);
    chk("reset_done", 32'(if4.done), 32'd0);
    chk("reset_result", if4.result, 32'd0);
    chk("reset_flags", {28'd0, if4.carry, if4.overflow, if4.zero, if4.neg}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      issue(1'b0, vecs[i], 1'b1);
      drain();
    end

    // Start held into DONE: second operation accepted back to back.
    @(negedge clk);
    issue(1'b0, vecs[0], 1'b1);
    for (int i = 0; i < 20 && !if4.done; i++) @(negedge clk);
    chk("b2b_done_seen", 32'(if4.done), 32'd1);
    issue(1'b0, vecs[2], 1'b1);
    drain();

    // Start pulsed mid-run with different operands must be ignored.
    @(negedge clk);
    issue(1'b0, vecs[5], 1'b1);
    @(negedge clk);
    if4.start = 1'b1; if4.op = junk.op; if4.a = junk.a; if4.b = junk.b;
    @(negedge clk);
    if4.start = 1'b0;
    chk("busy_ignored_start", 32'(if4.busy), 32'd1);
    drain();

    // Reset mid-operation: outputs clear at once and no done pulse follows.
    @(negedge clk);
    issue(1'b0, vecs[0], 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(if4.busy), 32'd0);
    chk("midrst_result", if4.result, 32'd0);
    chk("midrst_flags", {27'd0, if4.done, if4.carry, if4.overflow, if4.zero, if4.neg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_idle_busy", 32'(if4.busy), 32'd0);

    // Single-cycle configuration.
    @(negedge clk);
    issue(1'b1, vecs[0], 1'b1);
    drain();
    @(negedge clk);
    issue(1'b1, vecs[3], 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
